uart_rx_oversampled: RTL

Line-side UART receiver for an external serial input, the far end of the link driven by the team's UART transmitter. It synchronizes the asynchronous `rx` pin and generates its own 16x oversampling tick. It validates the start bit at mid-bit, samples 8N1 frames LSB first and buffers completed bytes in a small show-ahead FIFO. A host reads that FIFO with a pop strobe. Framing and overrun errors are reported as sticky flags.

---
 rtl/uart_rx_oversampled.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: two-flop input synchronizer, 16x oversampling tick,
// mid-bit start validation, show-ahead receive FIFO and sticky error flags.
module uart_rx_oversampled #(
  parameter int TICK_DIV   = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  logic          sync1_q, rxs_q;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          tick_s;
  state_e        state_q, state_d;
  logic [3:0]    scnt_q, scnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          push_s, ferr_set_s;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          full_s, empty_s, pop_s, wr_s, ovr_set_s;
  logic [7:0]    dout_q, dout_d;
  logic          rdy_q, rdy_d, ferr_q, ferr_d, ovr_q, ovr_d;

  // Oversample tick divider.
  always_comb begin
    tick_s = (tcnt_q == TICK_MAX);
    if (tick_s) begin
      tcnt_d = {CW{1'b0}};
    end else begin
      tcnt_d = tcnt_q + CW'(1);
    end
  end

  // Receive FSM: every transition is qualified by the oversample tick.
  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    bidx_d     = bidx_q;
    shreg_d    = shreg_q;
    push_s     = 1'b0;
    ferr_set_s = 1'b0;
    if (tick_s) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_d = S_START;
            scnt_d  = 4'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_START: begin
          if (scnt_q == 4'd7) begin
            scnt_d = 4'd0;
            bidx_d = 3'd0;
            if (!rxs_q) begin
              state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        S_DATA: begin
          if (scnt_q == 4'd15) begin
            shreg_d = {rxs_q, shreg_q[7:1]};
            bidx_d  = bidx_q + 3'd1;
            scnt_d  = 4'd0;
            if (bidx_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        S_STOP: begin
          if (scnt_q == 4'd15) begin
            scnt_d = 4'd0;
            if (rxs_q) begin
              push_s  = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_set_s = 1'b1;
              state_d    = S_BREAK;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        S_BREAK: begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_BREAK;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FIFO pointers, push/pop arbitration and next values of the registered outputs.
  always_comb begin
    empty_s   = (wptr_q == rptr_q);
    full_s    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop_s     = rd_en && !empty_s;
    wr_s      = push_s && (!full_s || pop_s);
    ovr_set_s = push_s && full_s && !pop_s;
    wptr_d    = wr_s  ? (wptr_q + PW'(1)) : wptr_q;
    rptr_d    = pop_s ? (rptr_q + PW'(1)) : rptr_q;
    rdy_d     = (wptr_d != rptr_d);
    // A byte written into an empty FIFO becomes the head in the same edge.
    if (!rdy_d) begin
      dout_d = 8'h00;
    end else if (wr_s && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) begin
      dout_d = shreg_q;
    end else begin
      dout_d = mem_q[rptr_d[AW-1:0]];
    end
    if (ferr_set_s) begin
      ferr_d = 1'b1;
    end else if (err_clr) begin
      ferr_d = 1'b0;
    end else begin
      ferr_d = ferr_q;
    end
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (err_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State, synchronizer and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      tcnt_q  <= {CW{1'b0}};
      state_q <= S_IDLE;
      scnt_q  <= 4'd0;
      bidx_q  <= 3'd0;
      shreg_q <= 8'h00;
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      dout_q  <= 8'h00;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
      tcnt_q  <= tcnt_d;
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_s) begin
      mem_q[wptr_q[AW-1:0]] <= shreg_q;
    end else begin
      mem_q <= mem_q;
    end
  end

  assign dout      = dout_q;
  assign rdy       = rdy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule
